// File: rtl/updown_mod_cnt_pkg.sv
// Shared constants and helpers for the up/down modulus counter family.
// Direction encodings and the all-ones default modulus generator.
package cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // All-ones value of the given width, saturating at 32 bits.
    function automatic logic [31:0] max_of(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/updown_mod_cnt_if.sv
// Control/status bundle of one counter stage.
// The master drives the controls; the counter (slave) returns count and flags.
interface updown_mod_cnt_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_max;
    logic [WIDTH-1:0] dout;
    logic             tc;
    logic             cout;
    logic             bout;
    logic             wrap;

    modport master (
        output en, up, load, load_val, cfg_we, cfg_max,
        input  dout, tc, cout, bout, wrap
    );

    modport slave (
        input  en, up, load, load_val, cfg_we, cfg_max,
        output dout, tc, cout, bout, wrap
    );
endinterface

// File: rtl/updown_mod_cnt_tc_detect.sv
// Combinational terminal-count and carry/borrow detection for one counter stage.
// 'active' low (reset asserted) forces every flag low.
module cnt_tc_detect
    import cnt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] dout,
    input  logic [WIDTH-1:0] max_reg,
    input  logic             en,
    input  logic             up,
    input  logic             active,
    output logic             at_max,
    output logic             at_zero,
    output logic             tc,
    output logic             cout,
    output logic             bout
);

    assign at_max  = (dout == max_reg);
    assign at_zero = (dout == '0);

    assign tc   = active & ((up == CNT_UP) ? at_max : at_zero);
    assign cout = active & en & (up == CNT_UP) & at_max;
    assign bout = active & en & (up == CNT_DN) & at_zero;

endmodule

// File: rtl/updown_mod_cnt.sv
// Up/down counter with runtime modulus, clamped synchronous load and cascade outputs.
// Priority per edge: modulus write, then load, then count step.
module updown_mod_cnt
    import cnt_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] DEFAULT_MAX = WIDTH'(max_of(WIDTH))
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_mod_cnt_if.slave      bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic             wrap_reg, wrap_next;
    logic             at_max, at_zero;
    logic             tc_w, cout_w, bout_w;

    cnt_tc_detect #(
        .WIDTH (WIDTH)
    ) u_tc_detect (
        .dout    (dout_reg),
        .max_reg (max_reg),
        .en      (bus.en),
        .up      (bus.up),
        .active  (~rst),
        .at_max  (at_max),
        .at_zero (at_zero),
        .tc      (tc_w),
        .cout    (cout_w),
        .bout    (bout_w)
    );

    always_comb begin
        dout_next = dout_reg;
        max_next  = max_reg;
        wrap_next = 1'b0;
        if (bus.cfg_we) begin
            max_next = bus.cfg_max;
            if (bus.load) begin
                dout_next = (bus.load_val > bus.cfg_max) ? bus.cfg_max : bus.load_val;
            end else if (dout_reg > bus.cfg_max) begin
                dout_next = '0;
            end
        end else if (bus.load) begin
            // Out-of-range loads clamp to the modulus and never count as a wrap.
            dout_next = (bus.load_val > max_reg) ? max_reg : bus.load_val;
        end else if (bus.en) begin
            if (bus.up == CNT_UP) begin
                if (at_max) begin
                    dout_next = '0;
                    wrap_next = 1'b1;
                end else begin
                    dout_next = dout_reg + ONE;
                end
            end else begin
                if (at_zero) begin
                    dout_next = max_reg;
                    wrap_next = 1'b1;
                end else begin
                    dout_next = dout_reg - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg <= '0;
            max_reg  <= DEFAULT_MAX;
            wrap_reg <= 1'b0;
        end else begin
            dout_reg <= dout_next;
            max_reg  <= max_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bus.dout = dout_reg;
    assign bus.wrap = wrap_reg;
    assign bus.tc   = tc_w;
    assign bus.cout = cout_w;
    assign bus.bout = bout_w;

endmodule

// File: tb/tb_updown_mod_cnt.sv
// Directed bench for updown_mod_cnt: a 16-bit stage against a modular-arithmetic model,
// plus a two-stage 4-bit cascade checked as a single 8-bit count.
module tb_updown_mod_cnt;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    updown_mod_cnt_if #(.WIDTH(16)) a_if ();
    updown_mod_cnt_if #(.WIDTH(4))  lo_if ();
    updown_mod_cnt_if #(.WIDTH(4))  hi_if ();

    updown_mod_cnt #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(a_if.slave));
    updown_mod_cnt #(.WIDTH(4))  u_lo (.clk(clk), .rst(rst), .bus(lo_if.slave));
    updown_mod_cnt #(.WIDTH(4))  u_hi (.clk(clk), .rst(rst), .bus(hi_if.slave));

    assign hi_if.en = lo_if.cout;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the 16-bit stage: count modulo (max+1).
    longint m_cnt = 0;
    longint m_max = 64'hFFFF;
    longint m_wrap = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_max  <= 64'hFFFF;
            m_wrap <= 0;
        end else begin
            m_wrap <= 0;
            if (a_if.cfg_we) begin
                m_max <= a_if.cfg_max;
                if (a_if.load)
                    m_cnt <= (a_if.load_val < a_if.cfg_max) ? a_if.load_val : a_if.cfg_max;
                else if (m_cnt > a_if.cfg_max)
                    m_cnt <= 0;
            end else if (a_if.load) begin
                m_cnt <= (a_if.load_val < m_max) ? a_if.load_val : m_max;
            end else if (a_if.en) begin
                if (a_if.up) begin
                    m_cnt  <= (m_cnt + 1) % (m_max + 1);
                    m_wrap <= (m_cnt + 1 == m_max + 1);
                end else begin
                    m_cnt  <= (m_cnt + m_max) % (m_max + 1);
                    m_wrap <= (m_cnt == 0);
                end
            end
        end
    end

    // Model of the cascade as one 8-bit up counter.
    longint c_val = 0;
    longint c_hiwrap = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_val    <= 0;
            c_hiwrap <= 0;
        end else begin
            c_hiwrap <= 0;
            if (lo_if.load && hi_if.load) begin
                c_val <= hi_if.load_val * 16 + lo_if.load_val;
            end else if (lo_if.en) begin
                c_val    <= (c_val + 1) % 256;
                c_hiwrap <= (c_val == 255);
            end
        end
    end

    always @(negedge clk) begin
        check("dout", a_if.dout, m_cnt);
        check("wrap", a_if.wrap, m_wrap);
        check("tc",   a_if.tc,   !rst && (a_if.up ? (m_cnt == m_max) : (m_cnt == 0)));
        check("cout", a_if.cout, !rst && a_if.en && a_if.up && (m_cnt == m_max));
        check("bout", a_if.bout, !rst && a_if.en && !a_if.up && (m_cnt == 0));
        check("casc_val",  {hi_if.dout, lo_if.dout}, c_val);
        check("casc_wrap", hi_if.wrap, c_hiwrap);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic en, input logic up, input logic load, input logic [15:0] lv,
                         input logic we, input logic [15:0] mx);
        a_if.en = en; a_if.up = up; a_if.load = load; a_if.load_val = lv;
        a_if.cfg_we = we; a_if.cfg_max = mx;
    endtask

    int hi_wraps = 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        set_a(0, 1, 0, 16'h0, 0, 16'h0);
        lo_if.en = 0; lo_if.up = 1; lo_if.load = 0; lo_if.load_val = '0;
        lo_if.cfg_we = 0; lo_if.cfg_max = '0;
        hi_if.up = 1; hi_if.load = 0; hi_if.load_val = '0; hi_if.cfg_we = 0; hi_if.cfg_max = '0;
        #2 rst = 1;
        @(negedge clk);
        check("rst_dout", a_if.dout, 0);
        check("rst_tc", a_if.tc, 0);
        cyc();
        rst = 0;

        $display("txn 1: load FFFE, count up twice");
        set_a(0, 1, 1, 16'hFFFE, 0, 16'h0);
        cyc();
        set_a(1, 1, 0, 16'h0, 0, 16'h0);
        cyc();
        @(negedge clk);
        check("t1_ffff", a_if.dout, 16'hFFFF);
        check("t1_cout", a_if.cout, 1);
        cyc();
        @(negedge clk);
        check("t1_zero", a_if.dout, 16'h0000);
        check("t1_wrap", a_if.wrap, 1);
        set_a(0, 1, 0, 16'h0, 0, 16'h0);
        cyc();

        $display("txn 2: modulus 9, count down from 0");
        set_a(0, 0, 0, 16'h0, 1, 16'd9);
        cyc();
        set_a(0, 0, 1, 16'd0, 0, 16'h0);
        cyc();
        set_a(1, 0, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("t2_bout", a_if.bout, 1);
        cyc();
        @(negedge clk);
        check("t2_nine", a_if.dout, 9);
        check("t2_wrap", a_if.wrap, 1);
        cyc();
        set_a(0, 0, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("t2_eight", a_if.dout, 8);

        $display("txn 3: clamped loads");
        set_a(0, 1, 1, 16'd12, 0, 16'h0);
        cyc();
        @(negedge clk);
        check("t3_clamp", a_if.dout, 9);
        set_a(0, 1, 1, 16'd5, 1, 16'd3);
        cyc();
        @(negedge clk);
        check("t3_cfgload", a_if.dout, 3);

        $display("txn 4: shrink modulus below count while enabled");
        set_a(0, 1, 1, 16'd8, 1, 16'd9);
        cyc();
        set_a(1, 1, 0, 16'h0, 1, 16'd5);
        cyc();
        set_a(0, 1, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("t4_zero", a_if.dout, 0);
        check("t4_nowrap", a_if.wrap, 0);

        $display("txn 5: modulus 0, both directions");
        set_a(0, 1, 0, 16'h0, 1, 16'd0);
        cyc();
        set_a(1, 1, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("m0_cout", a_if.cout, 1);
        cyc();
        set_a(1, 0, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("m0_wrap", a_if.wrap, 1);
        check("m0_bout", a_if.bout, 1);
        cyc();
        set_a(0, 1, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("m0_dout", a_if.dout, 0);

        $display("txn 6: async reset while counting at 1234");
        set_a(0, 1, 1, 16'h1233, 1, 16'hFFFF);
        cyc();
        set_a(1, 1, 0, 16'h0, 0, 16'h0);
        cyc();
        check("t5_pre", a_if.dout, 16'h1234);
        #2 rst = 1;
        #1;
        check("t5_dout", a_if.dout, 0);
        check("t5_wrap", a_if.wrap, 0);
        check("t5_cout", a_if.cout, 0);
        #1 rst = 0;
        set_a(0, 1, 0, 16'h0, 0, 16'h0);
        cyc();
        set_a(0, 1, 1, 16'hFFFF, 0, 16'h0);
        cyc();
        set_a(0, 1, 0, 16'h0, 0, 16'h0);
        @(negedge clk);
        check("t5_maxlost", a_if.dout, 16'hFFFF);

        $display("txn 7: 4-bit cascade FE -> FF -> 00");
        lo_if.load = 1; lo_if.load_val = 4'hE;
        hi_if.load = 1; hi_if.load_val = 4'hF;
        cyc();
        lo_if.load = 0; hi_if.load = 0; lo_if.en = 1;
        @(negedge clk);
        check("c_fe", {hi_if.dout, lo_if.dout}, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (hi_if.wrap) hi_wraps++;
            @(negedge clk);
            if (i == 0) check("c_ff", {hi_if.dout, lo_if.dout}, 8'hFF);
            if (i == 1) check("c_00", {hi_if.dout, lo_if.dout}, 8'h00);
        end
        lo_if.en = 0;
        check("c_hiwraps", hi_wraps, 1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
